// File: rtl/mov8_pkg.sv
// Shared types for the 8-register move sequencer: FSM states, register index
// type and the named register indices.
package mov8_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        LOAD,
        HOLD,
        DONE
    } state_t;

    typedef logic [2:0] reg_idx_t;

    localparam reg_idx_t REG_A  = 3'd0;
    localparam reg_idx_t REG_B  = 3'd1;
    localparam reg_idx_t REG_C  = 3'd2;
    localparam reg_idx_t REG_D  = 3'd3;
    localparam reg_idx_t REG_M1 = 3'd4;
    localparam reg_idx_t REG_M2 = 3'd5;
    localparam reg_idx_t REG_X  = 3'd6;
    localparam reg_idx_t REG_Y  = 3'd7;

    function automatic logic [7:0] onehot8(input reg_idx_t idx);
        onehot8 = 8'b1 << idx;
    endfunction

endpackage

// File: rtl/mov8_phase_timer.sv
// Loadable down-counter timing each sequencer phase; tc is high while the
// count sits at zero, i.e. in the last cycle of a phase.
module mov8_phase_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/mov8_sequencer.sv
// Register-to-register move sequencer: select source, strobe destination load,
// hold select, pulse done. Optional MOV8_SAME_REG_ABORT_EN adds err port.
module mov8_sequencer
    import mov8_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int LOAD_CYC   = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] src,
    input  logic [2:0] dst,
    output logic [7:0] sel,
    output logic [7:0] ld,
    output logic       busy,
    output logic       done
`ifdef MOV8_SAME_REG_ABORT_EN
    ,
    output logic       err
`endif
);

    localparam int MAX_CYC = (SETTLE_CYC > LOAD_CYC) ?
                             ((SETTLE_CYC > HOLD_CYC) ? SETTLE_CYC : HOLD_CYC) :
                             ((LOAD_CYC > HOLD_CYC) ? LOAD_CYC : HOLD_CYC);
    localparam int CNT_W = $clog2(MAX_CYC + 1);

    // Timer is loaded with length-1 so tc marks the final cycle of the phase.
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] LOAD_LD   = CNT_W'(LOAD_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

    state_t           state, state_nx;
    reg_idx_t         src_q, dst_q;
    logic             accept;
    logic             same_abort;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tc;

`ifdef MOV8_SAME_REG_ABORT_EN
    assign same_abort = (src == dst);
`else
    assign same_abort = 1'b0;
`endif

    mov8_phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (tmr_load),
        .load_val(tmr_val),
        .tc      (tc)
    );

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            IDLE: begin
                if (start && !same_abort) begin
                    accept   = 1'b1;
                    state_nx = SELECT;
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LD;
                end
            end
            SELECT: begin
                if (tc) begin
                    state_nx = LOAD;
                    tmr_load = 1'b1;
                    tmr_val  = LOAD_LD;
                end
            end
            LOAD: begin
                if (tc) begin
                    state_nx = HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LD;
                end
            end
            HOLD: begin
                if (tc) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            src_q <= REG_A;
            dst_q <= REG_A;
        end else begin
            state <= state_nx;
            if (accept) begin
                src_q <= src;
                dst_q <= dst;
            end
        end
    end

`ifdef MOV8_SAME_REG_ABORT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else begin
            err <= (state == IDLE) && start && same_abort;
        end
    end
`endif

    // Strobes decode from registered state only, so reset clears them at once.
    assign sel  = (state == SELECT || state == LOAD || state == HOLD) ? onehot8(src_q) : 8'h00;
    assign ld   = (state == LOAD && src_q != dst_q) ? onehot8(dst_q) : 8'h00;
    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: doc/mov8_sequencer.md
MOV8_SEQUENCER -- requirements
Module: mov8_sequencer

Interface
REQ-001 The block SHALL have parameter SETTLE_CYC, default 2, meaning cycles the source select is held before load asserts (min 1).
REQ-002 The block SHALL have parameter LOAD_CYC, default 2, meaning cycles the load strobe is held (min 1).
REQ-003 The block SHALL have parameter HOLD_CYC, default 1, meaning cycles the select is held after load drops (min 1).
REQ-004 The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-005 The block SHALL have port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit: request a register-to-register move.
REQ-008 The block SHALL have port src, input, 3 bits: source register index (A,B,C,D,M1,M2,X,Y = 0..7).
REQ-009 The block SHALL have port dst, input, 3 bits: destination register index (same encoding).
REQ-010 The block SHALL have port sel, output, 8 bits: one-hot source select strobes (sel[i] drives selX of register i onto the data bus).
REQ-011 The block SHALL have port ld, output, 8 bits: one-hot destination load strobes.
REQ-012 The block SHALL have port busy, output, 1 bit: a move is in progress.
REQ-013 The block SHALL have port done, output, 1 bit: single-cycle completion pulse.

Function
REQ-014 The block SHALL implement FSM states IDLE, SELECT, LOAD, HOLD, DONE.
REQ-015 In IDLE, start=1 SHALL latch src/dst into internal registers and move to SELECT on that edge; start in any other state SHALL be ignored.
REQ-016 SELECT SHALL last SETTLE_CYC cycles, LOAD LOAD_CYC cycles, HOLD HOLD_CYC cycles, DONE exactly 1 cycle, then return to IDLE.
REQ-017 sel[src_latched] SHALL be 1 in SELECT, LOAD and HOLD; all other sel bits SHALL be 0 at all times.
REQ-018 ld[dst_latched] SHALL be 1 only in LOAD; ld SHALL never assert outside a cycle where sel is already asserted (load never precedes select, select never drops before load).
REQ-019 busy SHALL be 1 in SELECT, LOAD, HOLD and DONE; done SHALL be 1 only in DONE.
REQ-020 With defaults and start sampled at edge 0: sel high cycles 1-5, ld high cycles 3-4, done high cycle 6, earliest next accepted start edge 7.
REQ-021 src/dst input changes after acceptance SHALL NOT affect the running move.
REQ-022 The phase counter SHALL be wide enough for max(SETTLE_CYC, LOAD_CYC, HOLD_CYC) and SHALL reload on each phase entry.

Reset
REQ-023 Asserting reset SHALL immediately force IDLE, sel=0, ld=0, busy=0, done=0, counter=0, latched src/dst=0, including mid-move.
REQ-024 A start held high during reset release SHALL be accepted on the first rising clk edge after reset deasserts.

Configuration
REQ-025 The block SHALL support the macro MOV8_SAME_REG_ABORT_EN.
REQ-026 When MOV8_SAME_REG_ABORT_EN is defined, the block SHALL add output err (1 bit), reset 0.
REQ-027 When MOV8_SAME_REG_ABORT_EN is defined and start with src==dst arrives in IDLE, err SHALL pulse for 1 cycle, the FSM SHALL stay in IDLE, and no sel/ld/done SHALL assert.
REQ-028 When MOV8_SAME_REG_ABORT_EN is undefined, there SHALL be no err port, and src==dst SHALL run the full sequence with ld held 0 throughout.

Structure
REQ-029 Package mov8_pkg SHALL hold the state enum, the 3-bit reg index typedef, and the named register index constants (REG_A..REG_Y).
REQ-030 The block SHALL use one sub-module, mov8_phase_timer, a loadable down-counter with a terminal-count output.

Verification
REQ-031 Scenario: start, src=0 (A), dst=1 (B), defaults -> sel=0x01 in cycles 1-5, ld=0x02 in cycles 3-4, done in cycle 6.
REQ-032 Scenario: start held high continuously -> moves accepted at edges 0, 7, 14; no overlap of sel.
REQ-033 Scenario: reset asserted in cycle 3 of a move -> sel/ld/busy read 0 before the next clk edge; the FSM is IDLE.
REQ-034 Scenario: src=6, dst=3, and src/dst changed to 0/0 in cycle 2 -> sel=0x40, ld=0x08 are unaffected.
REQ-035 Scenario: src=dst=2 -> with the macro, err pulse and no strobes; without the macro, sel=0x04 in cycles 1-5, ld=0, done in cycle 6.
REQ-036 Scenario: SETTLE_CYC=1, LOAD_CYC=1, HOLD_CYC=1 -> sel in cycles 1-3, ld in cycle 2, done in cycle 4.
